// File: rtl/lookahead_carry_unit.sv
// lookahead_carry_unit: registered N-bit carry-lookahead group stage.
// Define LCU_INPUT_REG_EN to add an input register stage (latency 2).
module lookahead_carry_unit #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] P,
  input  logic [N-1:0] G,
  input  logic         c_in,
  output logic         out_valid,
  output logic [N-1:0] C,
  output logic         BP,
  output logic         BG
);

  logic         vld_s;
  logic [N-1:0] p_s;
  logic [N-1:0] g_s;
  logic         ci_s;

`ifdef LCU_INPUT_REG_EN
  logic         vld_in_q;
  logic [N-1:0] p_q;
  logic [N-1:0] g_q;
  logic         ci_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_in_q <= 1'b0;
      p_q      <= '0;
      g_q      <= '0;
      ci_q     <= 1'b0;
    end else begin
      vld_in_q <= in_valid;
      p_q      <= P;
      g_q      <= G;
      ci_q     <= c_in;
    end
  end

  assign vld_s = vld_in_q;
  assign p_s   = p_q;
  assign g_s   = g_q;
  assign ci_s  = ci_q;
`else
  assign vld_s = in_valid;
  assign p_s   = P;
  assign g_s   = G;
  assign ci_s  = c_in;
`endif

  logic [N-1:0] c_d;
  logic         bp_d;
  logic         bg_d;
  logic         prod;

  // Each carry is a flat OR of terms P[i]..P[j+1]G[j] plus the c_in term.
  always_comb begin
    c_d  = '0;
    bp_d = &p_s;
    bg_d = 1'b0;
    prod = 1'b0;
    for (int i = 0; i < N; i++) begin
      prod   = p_s[i];
      c_d[i] = g_s[i];
      for (int j = i - 1; j >= 0; j--) begin
        c_d[i] = c_d[i] | (prod & g_s[j]);
        prod   = prod & p_s[j];
      end
      c_d[i] = c_d[i] | (prod & ci_s);
    end
    prod = p_s[N-1];
    bg_d = g_s[N-1];
    for (int j = N - 2; j >= 0; j--) begin
      bg_d = bg_d | (prod & g_s[j]);
      prod = prod & p_s[j];
    end
  end

  logic         vld_q;
  logic [N-1:0] c_q;
  logic         bp_q;
  logic         bg_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      c_q   <= '0;
      bp_q  <= 1'b0;
      bg_q  <= 1'b0;
    end else begin
      vld_q <= vld_s;
      if (vld_s) begin
        c_q  <= c_d;
        bp_q <= bp_d;
        bg_q <= bg_d;
      end
    end
  end

  assign out_valid = vld_q;
  assign C         = c_q;
  assign BP        = bp_q;
  assign BG        = bg_q;

endmodule

// File: tb/tb_lookahead_carry_unit.sv
// tb_lookahead_carry_unit: random + directed check against a ripple model.
// Tracks latency 1, or 2 when LCU_INPUT_REG_EN is defined.
module tb_lookahead_carry_unit;

  localparam int N = 4;
`ifdef LCU_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [N-1:0] P;
  logic [N-1:0] G;
  logic         c_in;
  logic         out_valid;
  logic [N-1:0] C;
  logic         BP;
  logic         BG;

  lookahead_carry_unit #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .P        (P),
    .G        (G),
    .c_in     (c_in),
    .out_valid(out_valid),
    .C        (C),
    .BP       (BP),
    .BG       (BG)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs;
  int checks;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: carry defined as a bit-serial ripple of the spec rule.
  function automatic logic [N-1:0] ripple(input logic [N-1:0] p,
                                          input logic [N-1:0] g,
                                          input logic ci);
    logic [N-1:0] r;
    logic c;
    c = ci;
    for (int i = 0; i < N; i++) begin
      c = g[i] | (p[i] & c);
      r[i] = c;
    end
    return r;
  endfunction

  // Model state: optional input stage, then output register.
  logic         s_v;
  logic [N-1:0] s_p, s_g;
  logic         s_c;
  logic         m_v;
  logic [N-1:0] m_c;
  logic         m_bp, m_bg, m_ci;

  task automatic tick();
    logic         src_v;
    logic [N-1:0] src_p, src_g;
    logic         src_c;
    if (LAT == 2) begin
      src_v = s_v; src_p = s_p; src_g = s_g; src_c = s_c;
    end else begin
      src_v = in_valid; src_p = P; src_g = G; src_c = c_in;
    end
    if (!rst_n) begin
      m_v = 0; m_c = '0; m_bp = 0; m_bg = 0; m_ci = 0;
      s_v = 0; s_p = '0; s_g = '0; s_c = 0;
    end else begin
      m_v = src_v;
      if (src_v) begin
        m_c  = ripple(src_p, src_g, src_c);
        m_bp = &src_p;
        m_bg = ripple(src_p, src_g, 1'b0) >> (N - 1);
        m_ci = src_c;
      end
      s_v = in_valid; s_p = P; s_g = G; s_c = c_in;
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_v);
    chk("C", C, m_c);
    chk("BP", BP, m_bp);
    chk("BG", BG, m_bg);
    if (m_v)
      chk("C_msb_inv", C[N-1], BG | (BP & m_ci));
  endtask

  task automatic drive(input logic v, input logic [N-1:0] p,
                       input logic [N-1:0] g, input logic ci);
    in_valid = v; P = p; G = g; c_in = ci;
  endtask

  task automatic idle_flush();
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    repeat (LAT) tick();
  endtask

  initial begin
    errs = 0;
    checks = 0;
    s_v = 0; s_p = '0; s_g = '0; s_c = 0;
    m_v = 0; m_c = '0; m_bp = 0; m_bg = 0; m_ci = 0;
    rst_n = 1'b0;
    drive(1'b1, 4'hF, 4'hF, 1'b1);
    repeat (2) tick();
    chk("rst_C", C, 0);
    chk("rst_valid", out_valid, 0);

    rst_n = 1'b1;
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    tick();
    drive(1'b1, 4'b0010, 4'b0100, 1'b0); tick(); idle_flush();
    drive(1'b1, 4'b0101, 4'b1010, 1'b0); tick(); idle_flush();
    drive(1'b1, 4'b1010, 4'b0011, 1'b0); tick(); idle_flush();
    drive(1'b1, 4'b1111, 4'b0000, 1'b1); tick(); idle_flush();
    chk("crit_C1", C, 4'b1111);
    drive(1'b1, 4'b1111, 4'b0000, 1'b0); tick(); idle_flush();
    chk("crit_C0", C, 4'b0000);
    chk("crit_BP", BP, 1'b1);

    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'($urandom), 4'($urandom), 1'($urandom));
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
      tick();
    end

    for (int k = 0; k < 512; k++) begin
      drive(1'b1, 4'(k >> 5), 4'(k >> 1), 1'(k));
      rst_n = (k != 200);
      tick();
    end
    rst_n = 1'b1;

    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      rst_n = ($urandom_range(0, 19) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
